// File: rtl/div32bit_seq_if.sv
// -----------------------------------------------------------------------------
// div32bit_seq_if
//
// Purpose: request/result bundle between a controlling FSM and the sequential
// unsigned divider div32bit_seq. Clock and reset are not part of the bundle.
//
// Signals:
//   start        controller -> divider  request, honoured only when idle/done
//   a, b         controller -> divider  dividend / divisor, captured on accept
//   busy         divider -> controller  high while iterating
//   done         divider -> controller  one-cycle result-valid pulse
//   q, r         divider -> controller  quotient / remainder
//   div_by_zero  divider -> controller  set together with done when b was 0
//
// Modports:
//   master  the controlling side (drives start/a/b)
//   slave   the divider side (drives busy/done/q/r/div_by_zero)
// -----------------------------------------------------------------------------
interface div32bit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/div32bit_seq.sv
// -----------------------------------------------------------------------------
// div32bit_seq
//
// Purpose: sequential unsigned divider. Computes q = a / b and r = a % b with
// restoring division, one quotient bit per clock, behind a start/busy/done
// handshake.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset, overrides everything
//   bus   div32bit_seq_if.slave: start, a, b in; busy, done, q, r,
//         div_by_zero out
//
// Parameters:
//   WIDTH  operand / quotient / remainder width (>= 2), default 32
//
// Build option:
//   DIV32BIT_FAST_PATH_EN  when defined, operations with a < b or a == b
//                          (b != 0) bypass the iteration loop and finish in
//                          the same short time as a divide by zero. Results
//                          are identical with or without it.
//
// Timing (start accepted on edge 0):
//   iterative path : busy after edges 0..WIDTH-1, done after edge WIDTH
//   short path     : done after edge 1 (divide by zero, and fast path)
// -----------------------------------------------------------------------------
module div32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  div32bit_seq_if.slave  bus
);

  // Counter must hold 0..WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // S_QUICK is a one-cycle staging state used by every operation that does
  // not iterate: its result is already sitting in shift/rem and gets copied
  // to the output registers on the following edge, so those operations also
  // complete one edge after the accept.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_QUICK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder
  logic [WIDTH-1:0] shift_q, shift_d;  // dividend bits out of MSB, quotient bits in at LSB
  logic [WIDTH-1:0] div_q,   div_d;    // captured divisor
  logic [CW-1:0]    cnt_q,   cnt_d;    // iteration index
  logic [WIDTH-1:0] quo_q,   quo_d;    // quotient output register
  logic [WIDTH-1:0] rmd_q,   rmd_d;    // remainder output register
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             dbz_q,   dbz_d;

  logic             accept;
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] shift_step;

  // A request is only looked at when nothing is in flight.
  assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // One restoring step. The trial value is WIDTH+1 bits: the remainder is
  // always < divisor, but doubling it can exceed WIDTH bits when the divisor
  // has its MSB set, so the compare and subtract run one bit wider.
  assign trial      = {rem_q, shift_q[WIDTH-1]};
  assign trial_ge   = (trial >= {1'b0, div_q});
  assign rem_step   = trial_ge ? WIDTH'(trial - {1'b0, div_q}) : trial[WIDTH-1:0];
  assign shift_step = {shift_q[WIDTH-2:0], trial_ge};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // Outputs q/r keep the previous result until the new one is
          // registered; only the divide-by-zero flag is dropped right away.
          div_d = bus.b;
          dbz_d = 1'b0;
          cnt_d = '0;
          if (bus.b == '0) begin
            shift_d = '1;
            rem_d   = bus.a;
            busy_d  = 1'b0;
            state_d = S_QUICK;
          end
`ifdef DIV32BIT_FAST_PATH_EN
          else if (bus.a < bus.b) begin
            shift_d = '0;
            rem_d   = bus.a;
            busy_d  = 1'b0;
            state_d = S_QUICK;
          end
          else if (bus.a == bus.b) begin
            shift_d = WIDTH'(1);
            rem_d   = '0;
            busy_d  = 1'b0;
            state_d = S_QUICK;
          end
`endif
          else begin
            shift_d = bus.a;
            rem_d   = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        rem_d   = rem_step;
        shift_d = shift_step;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Final quotient bit has just been formed; publish the result.
          quo_d   = shift_step;
          rmd_d   = rem_step;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_QUICK: begin
        // Divisor of zero is the only way to reach here with div_q == 0.
        quo_d   = shift_q;
        rmd_d   = rem_q;
        dbz_d   = (div_q == '0);
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.q           = quo_q;
  assign bus.r           = rmd_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32bit_seq.sv
// -----------------------------------------------------------------------------
// tb_div32bit_seq
//
// Directed and random stimulus for div32bit_seq. Expected results come from
// plain '/' and '%' arithmetic; expected latency from the operand class.
// -----------------------------------------------------------------------------
module tb_div32bit_seq;

  localparam int W = 32;
`ifdef DIV32BIT_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  div32bit_seq_if #(.WIDTH(W)) bus_if ();

  div32bit_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Last result the bench expects the DUT to be holding.
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one division and follow it to its done pulse. Leaves the bench in
  // the done cycle with start low, so a following call is a back-to-back
  // accept. With noisy set, start/a/b toggle randomly while the DUT is busy.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    bit           quick;
    int           lat;
    int           busy_cnt;
    logic [63:0]  recon;

    if (b == '0) begin
      eq = '1; er = a; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
    quick = (b == '0) || (FAST && (a <= b));

    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    step();
    chk("dbz_clear_on_accept", 64'(bus_if.div_by_zero), 64'(0));
    chk("q_held_after_accept", 64'(bus_if.q), 64'(last_q));
    chk("r_held_after_accept", 64'(bus_if.r), 64'(last_r));
    busy_cnt = int'(bus_if.busy);
    lat = 0;
    bus_if.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noisy) begin
      bus_if.a = $urandom;
      bus_if.b = $urandom;
    end
    while (!bus_if.done && lat < 200) begin
      step();
      lat++;
      if (!bus_if.done) begin
        if (bus_if.busy) busy_cnt++;
        bus_if.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) begin
          bus_if.a = $urandom;
          bus_if.b = $urandom;
        end
      end
    end
    bus_if.start = 1'b0;

    chk("latency", 64'(lat), quick ? 64'(1) : 64'(W));
    chk("busy_cycles", 64'(busy_cnt), quick ? 64'(0) : 64'(W));
    chk("busy_in_done", 64'(bus_if.busy), 64'(0));
    chk("q", 64'(bus_if.q), 64'(eq));
    chk("r", 64'(bus_if.r), 64'(er));
    chk("div_by_zero", 64'(bus_if.div_by_zero), 64'(edz));
    if (b != '0) begin
      recon = 64'(bus_if.q) * 64'(b) + 64'(bus_if.r);
      chk("invariant_a_eq_qb_plus_r", recon, 64'(a));
      chk("invariant_r_lt_b", 64'(bus_if.r < b), 64'(1));
    end
    $display("div a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dbz=%0d lat=%0d",
             a, b, bus_if.q, bus_if.r, bus_if.div_by_zero, lat);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(bus_if.busy), 64'(0));
    chk("rst_done", 64'(bus_if.done), 64'(0));
    chk("rst_q", 64'(bus_if.q), 64'(0));
    chk("rst_r", 64'(bus_if.r), 64'(0));
    chk("rst_dbz", 64'(bus_if.div_by_zero), 64'(0));
    rst = 1'b0;
    step();

    // Basic division, then confirm done is a single-cycle pulse
    run_div(32'd100, 32'd7, 1'b0);
    step();
    chk("done_one_cycle", 64'(bus_if.done), 64'(0));
    chk("q_hold_after_done", 64'(bus_if.q), 64'(14));
    chk("r_hold_after_done", 64'(bus_if.r), 64'(2));

    // Extremes
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step();

    // Divide by zero, followed by a normal division clearing the flag
    run_div(32'd1234, 32'd0, 1'b0);
    step();
    run_div(32'd9, 32'd3, 1'b0);
    step();

    // A second start while busy must be ignored
    bus_if.start = 1'b1;
    bus_if.a     = 32'd1000;
    bus_if.b     = 32'd3;
    step();
    bus_if.start = 1'b0;
    lat = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      lat++;
    end
    bus_if.start = 1'b1;
    bus_if.a     = 32'd5;
    bus_if.b     = 32'd5;
    step();
    bus_if.start = 1'b0;
    while (!bus_if.done && lat < 200) begin
      step();
      lat++;
    end
    chk("ignored_start_latency", 64'(lat), 64'(W));
    chk("ignored_start_q", 64'(bus_if.q), 64'(333));
    chk("ignored_start_r", 64'(bus_if.r), 64'(1));
    $display("div a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dbz=%0d lat=%0d (start pulsed mid-run)",
             32'd1000, 32'd3, bus_if.q, bus_if.r, bus_if.div_by_zero, lat);
    last_q = 32'd333;
    last_r = 32'd1;
    step();

    // Reset in the middle of a run: no done, outputs cleared
    bus_if.start = 1'b1;
    bus_if.a     = 32'd42000;
    bus_if.b     = 32'd7;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 64'(bus_if.busy), 64'(0));
    chk("midrst_done", 64'(bus_if.done), 64'(0));
    chk("midrst_q", 64'(bus_if.q), 64'(0));
    chk("midrst_r", 64'(bus_if.r), 64'(0));
    chk("midrst_dbz", 64'(bus_if.div_by_zero), 64'(0));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.done) done_cnt++;
    end
    chk("midrst_no_done", 64'(done_cnt), 64'(0));
    $display("reset mid-run: done pulses afterwards=%0d", done_cnt);
    last_q = '0;
    last_r = '0;

    // Back-to-back: second start issued in the done cycle of the first
    run_div(32'd77, 32'd5, 1'b0);
    run_div(32'd50, 32'd8, 1'b0);
    step();

    // Random operands, a mix of operand classes, b never zero
    for (int n = 0; n < 250; n++) begin
      rb = $urandom;
      if (rb == '0) rb = 32'd1;
      case ($urandom_range(0, 3))
        0: begin rb = $urandom_range(1, 1000); ra = $urandom; end
        1: ra = (rb == 32'd1) ? 32'd0 : 32'($urandom_range(0, 32'(rb - 32'd1)));
        2: ra = rb;
        default: ra = $urandom;
      endcase
      run_div(ra, rb, 1'((n % 2) == 1));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
